// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a programmable window,
// then streams one {channel, count} word per channel through a valid/ready port.
// Build option: define SPIKE_RATE_DECODER_SAT_EN for saturating counters;
// the default build wraps counters modulo 2^CNT_W.
module spike_rate_decoder #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] spike_in,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [CNT_W-1:0]  out_count,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [WIN_W-1:0] ONE_WIN = WIN_W'(1);

  state_t           state;
  logic [WIN_W-1:0] remain;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic             start_ok;
  logic             accum_en;

  // A start is taken only from IDLE, and never in the cycle done is pulsing.
  assign start_ok = (state == IDLE) && start && !done;
  assign accum_en = (state == ACCUM);

  // Main controller: window countdown, readout sequencing and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            // A zero length still gives a one-cycle window.
            remain <= (win_len == '0) ? ONE_WIN : win_len;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (remain == ONE_WIN) begin
            remain    <= '0;
            out_ch    <= '0;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else begin
            remain <= remain - ONE_WIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_ch == LAST_CH) begin
              out_valid <= 1'b0;
              out_ch    <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_ch <= out_ch + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One independent counter per channel; all channels may count in the same cycle.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] count_reg;

    // Clear on window start, count sampled spikes only while accumulating.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_reg <= '0;
      end else if (start_ok) begin
        count_reg <= '0;
      end else if (accum_en && spike_in[gi]) begin
`ifdef SPIKE_RATE_DECODER_SAT_EN
        if (count_reg != '1) begin
          count_reg <= count_reg + 1'b1;
        end
`else
        count_reg <= count_reg + 1'b1;
`endif
      end
    end

    assign cnt[gi] = count_reg;
  end

  // Readout mux is forced to zero whenever no word is being presented.
  assign out_count = out_valid ? cnt[out_ch] : '0;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table of full windows plus
// hand-written sequences for backpressure, reset mid-readout and held start.
`timescale 1ns/1ps
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spike_in;
  logic [7:0] win_len;
  logic       start;
  logic       out_ready;
  logic       busy, out_valid, done;
  logic [2:0] out_ch;
  logic [7:0] out_count;
  logic       busy4, out_valid4, done4;
  logic [2:0] out_ch4;
  logic [3:0] out_count4;

  int checks = 0;
  int errors = 0;

  // Saturating build holds at 15; wrapping build gives 17 mod 16.
`ifdef SPIKE_RATE_DECODER_SAT_EN
  localparam int W17_C4 = 15;
`else
  localparam int W17_C4 = 1;
`endif

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(8), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .win_len(win_len), .start(start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_count(out_count), .done(done)
  );

  // Narrow-counter copy sharing the same stimulus, used for the wrap/saturate case.
  spike_rate_decoder #(.NUM_CH(8), .CNT_W(4), .WIN_W(8)) dut4 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .win_len(win_len), .start(start),
    .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready), .out_ch(out_ch4),
    .out_count(out_count4), .done(done4)
  );

  typedef struct {
    int              win;
    logic [7:0]      spk;
    logic [7:0][7:0] exp;
    int              exp4;
    string           tag;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full window with out_ready held high; checks latency, every word and done.
  task automatic run_window(input vec_t v);
    int wl;
    wl = (v.win == 0) ? 1 : v.win;
    win_len   = v.win[7:0];
    spike_in  = v.spk;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({v.tag, "_busy"}, {31'd0, busy}, 32'd1);
    repeat (wl - 1) tick();
    chk({v.tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    spike_in = 8'h00;
    for (int ch = 0; ch < 8; ch++) begin
      chk({v.tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({v.tag, "_ch"}, {29'd0, out_ch}, ch);
      chk({v.tag, "_count"}, {24'd0, out_count}, {24'd0, v.exp[ch]});
      if (ch == 0) chk({v.tag, "_c4_ch0"}, {28'd0, out_count4}, v.exp4);
      tick();
    end
    chk({v.tag, "_done"}, {31'd0, done}, 32'd1);
    chk({v.tag, "_valid_off"}, {31'd0, out_valid}, 32'd0);
    chk({v.tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    tick();
    chk({v.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    $display("window %s win_len=%0d spikes=%02h checked", v.tag, v.win, v.spk);
  endtask

  initial begin
    vecs[0] = '{10,  8'hFF, {8{8'd10}},                                   10,     "w10_ff"};
    vecs[1] = '{0,   8'h01, {56'd0, 8'd1},                                 1,      "w0_01"};
    vecs[2] = '{3,   8'hA5, {8'd3, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 8'd0, 8'd3}, 3,  "w3_a5"};
    vecs[3] = '{1,   8'h80, {8'd1, 56'd0},                                 0,      "w1_80"};
    vecs[4] = '{255, 8'h01, {56'd0, 8'd255},                               15,     "w255_01"};
    vecs[5] = '{17,  8'h01, {56'd0, 8'd17},                                W17_C4, "w17_01"};

    rst = 1'b1; spike_in = 8'h00; win_len = 8'd0; start = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ch",    {29'd0, out_ch}, 32'd0);
    chk("rst_count", {24'd0, out_count}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    $display("reset state checked");
    // Spikes while idle must not leak into the next window.
    spike_in = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 6; i++) run_window(vecs[i]);

    // Backpressure: ch3 spikes on accumulation cycles 1 and 3, ch0 word held 5 cycles.
    win_len = 8'd4; start = 1'b1; out_ready = 1'b0; spike_in = 8'h00;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      spike_in = (k == 1 || k == 3) ? 8'h08 : 8'h00;
      win_len = 8'd200;
      tick();
    end
    spike_in = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ch",    {29'd0, out_ch}, 32'd0);
      chk("bp_hold_count", {24'd0, out_count}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int ch = 0; ch < 8; ch++) begin
      chk("bp_ch",    {29'd0, out_ch}, ch);
      chk("bp_count", {24'd0, out_count}, (ch == 3) ? 32'd2 : 32'd0);
      tick();
    end
    chk("bp_done", {31'd0, done}, 32'd1);
    $display("window backpressure w4 checked");
    tick();

    // Reset in the middle of readout abandons the window without done.
    win_len = 8'd2; spike_in = 8'hFF; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    spike_in = 8'h00;
    tick();
    tick();
    tick();
    chk("mid_ch_before_rst", {29'd0, out_ch}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {24'd0, out_count}, 32'd0);
    chk("mid_rst_ch",    {29'd0, out_ch}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_done", {31'd0, done}, 32'd0);
      chk("mid_rst_idle",    {31'd0, busy}, 32'd0);
      tick();
    end
    $display("reset mid-readout checked");
    run_window('{2, 8'hFF, {8{8'd2}}, 2, "after_rst"});

    // Start held high throughout: one window per IDLE entry, first win_len kept.
    win_len = 8'd3; spike_in = 8'h01; start = 1'b1; out_ready = 1'b1;
    tick();
    win_len = 8'd9;
    tick();
    tick();
    chk("hold_early_valid", {31'd0, out_valid}, 32'd0);
    tick();
    spike_in = 8'h00;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_count", {24'd0, out_count}, 32'd3);
    repeat (8) tick();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    chk("hold_done_cycle_ignored", {31'd0, busy}, 32'd0);
    chk("hold_done_once", {31'd0, done}, 32'd0);
    tick();
    chk("hold_restart", {31'd0, busy}, 32'd1);
    start = 1'b0;
    $display("held start sequence checked");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
